// File: rtl/cmd_seq_pkg.sv
// rtl/cmd_seq_pkg.sv - shared states, error codes and ASCII constants for the AT command sequencer
package cmd_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, RD_CNT, FETCH, SEND, SEND_CR, SEND_LF, WAIT_RESP, NEXT, FINISH
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_REPLY   = 2'd2,
    ERR_EMPTY   = 2'd3
  } err_code_t;

  localparam logic [7:0]  CR      = 8'h0D;
  localparam logic [7:0]  LF      = 8'h0A;
  localparam logic [7:0]  NUL     = 8'h00;
  localparam logic [15:0] OK_STR  = "OK";
  localparam logic [39:0] ERR_STR = "ERROR";

endpackage

// File: rtl/resp_matcher.sv
// rtl/resp_matcher.sv - pops modem reply bytes, assembles lines and flags OK / ERROR lines
module resp_matcher
  import cmd_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_rd_en,
  output logic       ok_pulse,
  output logic       err_pulse
);

  logic [4:0][7:0] line_buf;
  logic [2:0]      line_len;
  logic            rd_q;
  logic            line_end;

  // Pops are spaced one cycle apart so each byte is seen before the next pop decision.
  assign rx_rd_en  = enable && rx_valid && !rd_q;
  assign line_end  = enable && rd_q && (rx_data == LF);
  assign ok_pulse  = line_end && (line_len == 3'd2) && ({line_buf[0], line_buf[1]} == OK_STR);
  assign err_pulse = line_end && (line_len >= 3'd5) &&
                     ({line_buf[0], line_buf[1], line_buf[2], line_buf[3], line_buf[4]} == ERR_STR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= 1'b0;
      line_len <= '0;
      line_buf <= '0;
    end else if (!enable) begin
      rd_q     <= 1'b0;
      line_len <= '0;
    end else begin
      rd_q <= rx_rd_en;
      if (rd_q) begin
        if (rx_data == LF) begin
          line_len <= '0;
        end else if (rx_data != CR) begin
          if (line_len < 3'd5) line_buf[line_len] <= rx_data;
          if (line_len != 3'd7) line_len <= line_len + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - plays the stored AT command list over UART TX and checks each reply
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int CMD_WIDTH    = 32,
  parameter int CMD_DEPTH    = 16,
  parameter int ADDR_WIDTH   = $clog2(CMD_WIDTH*CMD_DEPTH+1),
  parameter int RESP_TIMEOUT = 5_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [7:0]                   mem_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_full,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_rd_en,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   error_code,
  output logic [$clog2(CMD_DEPTH)-1:0] cmd_idx
);

  localparam int IW = $clog2(CMD_DEPTH);
  localparam int JW = $clog2(CMD_WIDTH+1);
  localparam int NW = $clog2(CMD_DEPTH+1);
  localparam int TW = $clog2(RESP_TIMEOUT+1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(RESP_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT-1);

  seq_state_t      state;
  logic            rd_phase;
  logic [NW-1:0]   num_cmds;
  logic [JW-1:0]   byte_cnt;
  logic [TW-1:0]   resp_cnt;
  logic            tx_pend;
  logic            tx_free;
  logic            ok_pulse;
  logic            err_pulse;
  logic [NW-1:0]   idx_next;

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [IW-1:0] idx, input logic [JW-1:0] j);
    return ADDR_WIDTH'(idx) * ADDR_WIDTH'(CMD_WIDTH) + ADDR_WIDTH'(j) + ADDR_WIDTH'(1);
  endfunction

  // A loaded byte is held in tx_data until the FIFO has room, so strobes never hit a full FIFO.
  assign tx_valid = tx_pend && !tx_full;
  assign tx_free  = !tx_pend || !tx_full;
  assign idx_next = NW'(cmd_idx) + NW'(1);

  resp_matcher u_matcher (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (state == WAIT_RESP),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_rd_en  (rx_rd_en),
    .ok_pulse  (ok_pulse),
    .err_pulse (err_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_phase   <= 1'b0;
      num_cmds   <= '0;
      byte_cnt   <= '0;
      resp_cnt   <= '0;
      tx_pend    <= 1'b0;
      mem_addr   <= '0;
      tx_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error_code <= ERR_NONE;
      cmd_idx    <= '0;
    end else begin
      done <= 1'b0;
      if (tx_valid) tx_pend <= 1'b0;
      if (abort && state != IDLE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        tx_pend  <= 1'b0;
        rd_phase <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state      <= RD_CNT;
            busy       <= 1'b1;
            error_code <= ERR_NONE;
            cmd_idx    <= '0;
            mem_addr   <= '0;
            rd_phase   <= 1'b0;
          end
          // First cycle presents addr 0, second consumes the count.
          RD_CNT: if (!rd_phase) begin
            rd_phase <= 1'b1;
          end else begin
            rd_phase <= 1'b0;
            if (mem_data == NUL) begin
              error_code <= ERR_EMPTY;
              state      <= FINISH;
            end else begin
              num_cmds <= (int'(mem_data) > CMD_DEPTH) ? NW'(CMD_DEPTH) : NW'(mem_data);
              byte_cnt <= '0;
              mem_addr <= slot_addr('0, '0);
              state    <= FETCH;
            end
          end
          FETCH: state <= SEND;
          SEND: if (mem_data == NUL || mem_data == CR) begin
            state <= SEND_CR;
          end else if (tx_free) begin
            tx_data  <= mem_data;
            tx_pend  <= 1'b1;
            byte_cnt <= byte_cnt + JW'(1);
            if (byte_cnt == JW'(CMD_WIDTH-1)) begin
              state <= SEND_CR;
            end else begin
              mem_addr <= slot_addr(cmd_idx, byte_cnt + JW'(1));
              state    <= FETCH;
            end
          end
          SEND_CR: if (tx_free) begin
            tx_data <= CR;
            tx_pend <= 1'b1;
            state   <= SEND_LF;
          end
          SEND_LF: if (tx_free) begin
            tx_data  <= LF;
            tx_pend  <= 1'b1;
            resp_cnt <= '0;
            state    <= WAIT_RESP;
          end
          WAIT_RESP: begin
            if (ok_pulse) begin
              state <= NEXT;
            end else if (err_pulse) begin
              error_code <= ERR_REPLY;
              state      <= FINISH;
            end else if (resp_cnt >= TMO_LAST) begin
              error_code <= ERR_TIMEOUT;
              state      <= FINISH;
            end else if (resp_cnt != TMO_MAX) begin
              resp_cnt <= resp_cnt + TW'(1);
            end
          end
          NEXT: if (idx_next == num_cmds) begin
            state <= FINISH;
          end else begin
            cmd_idx  <= IW'(idx_next);
            byte_cnt <= '0;
            mem_addr <= slot_addr(IW'(idx_next), '0);
            state    <= FETCH;
          end
          FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
